// File: rtl/bnn_pkg.sv
// rtl/bnn_pkg.sv - shared constants for the binary neural network datapath
// Provides the operation encodings and the default widths used by the
// XNOR/popcount ALU wrapper, the accumulate/binarize stage and the ofmap writer.
package bnn_pkg;

  localparam logic OP_CONV = 1'b0;  // accumulate popcounts, then threshold
  localparam logic OP_POOL = 1'b1;  // pooled bit passes straight through

  localparam int DEF_ACC_W  = 13;   // 256 channels x 25 taps fits in 13 bits
  localparam int DEF_CH_W   = 8;
  localparam int DEF_PACK_W = 8;

endpackage

// File: rtl/bnn_bit_packer.sv
// rtl/bnn_bit_packer.sv - packs activation bits LSB-first into output words
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   push, push_bit       write push_bit at position pcnt this cycle
//   flush                emit the partial word (after any same-cycle push)
//   clear                drop pcnt and the pack register; output word untouched
//   out_ready            consumer accepts out_data
//   out_data, out_nbits  packed word and its count of valid bits
//   out_valid            out_data is valid
module bnn_bit_packer
  import bnn_pkg::*;
#(
  parameter int PACK_W = DEF_PACK_W,
  localparam int PC_W  = $clog2(PACK_W)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push,
  input  logic            push_bit,
  input  logic            flush,
  input  logic            clear,
  input  logic            out_ready,
  output logic [PACK_W-1:0] out_data,
  output logic [PC_W:0]   out_nbits,
  output logic            out_valid
);

  logic [PACK_W-1:0] pack;
  logic [PACK_W-1:0] pack_set;
  logic [PC_W-1:0]   pcnt;
  logic [PC_W:0]     fill;
  logic              full;
  logic              emit;

  // Word contents and bit count as they stand after this cycle's push.
  always_comb begin
    pack_set = pack;
    if (push) pack_set[pcnt] = push_bit;
  end

  assign fill = {1'b0, pcnt} + (PC_W+1)'(push);
  assign full = push && (pcnt == PC_W'(PACK_W - 1));
  // A flush on an empty word emits nothing; a full word is emitted once.
  assign emit = !clear && (full || (flush && (fill != '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack      <= '0;
      pcnt      <= '0;
      out_data  <= '0;
      out_nbits <= '0;
      out_valid <= 1'b0;
    end else begin
      if (clear || emit) begin
        pack <= '0;
        pcnt <= '0;
      end else if (push) begin
        pack <= pack_set;
        pcnt <= pcnt + PC_W'(1);
      end

      // A word loading on the same edge as a drain keeps out_valid high.
      if (emit) begin
        out_data  <= pack_set;
        out_nbits <= fill;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bnn_accum_binarize.sv
// rtl/bnn_accum_binarize.sv - popcount accumulation, binarization and packing
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   mac_in, mac_valid, in_ready ALU result stream and its handshake
//   operation                   OP_CONV accumulate/threshold, OP_POOL pass-through
//   num_ch                      channels per output pixel minus 1
//   threshold                   activation bit = (accumulated sum >= threshold)
//   clear                       synchronous clear of accumulation and packing
//   flush                       emit the partial pack word
//   out_data, out_nbits         packed activations and their valid bit count
//   out_valid, out_ready        output handshake
module bnn_accum_binarize
  import bnn_pkg::*;
#(
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CH_W   = DEF_CH_W,
  parameter int PACK_W = DEF_PACK_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4:0]                mac_in,
  input  logic                      mac_valid,
  output logic                      in_ready,
  input  logic                      operation,
  input  logic [CH_W-1:0]           num_ch,
  input  logic [ACC_W-1:0]          threshold,
  input  logic                      clear,
  input  logic                      flush,
  output logic [PACK_W-1:0]         out_data,
  output logic [$clog2(PACK_W):0]   out_nbits,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic [ACC_W-1:0] acc;
  logic [CH_W-1:0]  ch_cnt;
  logic [CH_W-1:0]  num_ch_lat;
  logic [CH_W-1:0]  ch_lim;
  logic [ACC_W:0]   sum_w;
  logic [ACC_W-1:0] sum_sat;
  logic             accept;
  logic             last;
  logic             push;
  logic             push_bit;
  logic             flush_s;

  // Only a stalled output word blocks input; no path from mac_valid.
  assign in_ready = !(out_valid && !out_ready);
  assign accept   = mac_valid && in_ready;
  assign flush_s  = flush && in_ready && !clear;

  assign sum_w   = {1'b0, acc} + (ACC_W+1)'(mac_in);
  assign sum_sat = sum_w[ACC_W] ? '1 : sum_w[ACC_W-1:0];

  // The first channel of a pixel uses the live num_ch, which is latched then.
  assign ch_lim = (ch_cnt == '0) ? num_ch : num_ch_lat;
  assign last   = (ch_cnt == ch_lim);

  assign push     = accept && !clear && ((operation == OP_POOL) || last);
  assign push_bit = (operation == OP_POOL) ? mac_in[0] : (sum_sat >= threshold);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      ch_cnt     <= '0;
      num_ch_lat <= '0;
    end else if (clear) begin
      acc    <= '0;
      ch_cnt <= '0;
    end else if (accept) begin
      if (ch_cnt == '0) num_ch_lat <= num_ch;
      if ((operation == OP_POOL) || last) begin
        acc    <= '0;
        ch_cnt <= '0;
      end else begin
        acc    <= sum_sat;
        ch_cnt <= ch_cnt + CH_W'(1);
      end
    end
  end

  bnn_bit_packer #(
    .PACK_W (PACK_W)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_bit  (push_bit),
    .flush     (flush_s),
    .clear     (clear),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_nbits (out_nbits),
    .out_valid (out_valid)
  );

endmodule

// File: tb/tb_bnn_accum_binarize.sv
// tb/tb_bnn_accum_binarize.sv - directed self-checking bench for bnn_accum_binarize
module tb_bnn_accum_binarize;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [4:0]  mac_in = '0;
  logic        mac_valid = 1'b0;
  logic        in_ready;
  logic        operation = 1'b0;
  logic [7:0]  num_ch = '0;
  logic [12:0] threshold = '0;
  logic        clear = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  out_data;
  logic [3:0]  out_nbits;
  logic        out_valid;
  logic        out_ready = 1'b1;

  logic [4:0]  b_mac_in = '0;
  logic        b_mac_valid = 1'b0;
  logic        b_in_ready;
  logic        b_operation = 1'b0;
  logic [7:0]  b_num_ch = '0;
  logic [4:0]  b_threshold = '0;
  logic        b_clear = 1'b0;
  logic        b_flush = 1'b0;
  logic [7:0]  b_out_data;
  logic [3:0]  b_out_nbits;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bnn_accum_binarize dut (
    .clk (clk), .rst_n (rst_n), .mac_in (mac_in), .mac_valid (mac_valid),
    .in_ready (in_ready), .operation (operation), .num_ch (num_ch),
    .threshold (threshold), .clear (clear), .flush (flush),
    .out_data (out_data), .out_nbits (out_nbits), .out_valid (out_valid),
    .out_ready (out_ready)
  );

  bnn_accum_binarize #(.ACC_W(5)) dut_sat (
    .clk (clk), .rst_n (rst_n), .mac_in (b_mac_in), .mac_valid (b_mac_valid),
    .in_ready (b_in_ready), .operation (b_operation), .num_ch (b_num_ch),
    .threshold (b_threshold), .clear (b_clear), .flush (b_flush),
    .out_data (b_out_data), .out_nbits (b_out_nbits), .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [4:0] v, input logic f);
    mac_valid = 1'b1;
    mac_in    = v;
    flush     = f;
    cyc();
    mac_valid = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic do_clear;
    clear = 1'b1;
    cyc();
    clear = 1'b0;
  endtask

  task automatic test_reset;
    cyc();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (out_nbits !== 4'd0) begin errors++; $display("FAIL reset_out_nbits: got %0d want 0", out_nbits); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_conv;
    operation = 1'b0; num_ch = 8'd2; threshold = 13'd20; out_ready = 1'b1;
    do_clear();
    for (int p = 0; p < 8; p++) begin
      send(5'd7, 1'b0);
      send(5'd8, 1'b0);
      if (p == 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_no_early_word: got %b want 0", out_valid); end
      end
      send((p % 2 == 0) ? 5'd6 : 5'd4, 1'b0);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL conv_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL conv_data: got %h want 55", out_data); end
    checks++; if (out_nbits !== 4'd8) begin errors++; $display("FAIL conv_nbits: got %0d want 8", out_nbits); end
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL conv_valid_one_cycle: got %b want 0", out_valid); end
  endtask

  task automatic test_num_ch;
    operation = 1'b0; num_ch = 8'd1; threshold = 13'd3;
    do_clear();
    send(5'd2, 1'b0);
    num_ch = 8'd5;
    send(5'd2, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_nbits !== 4'd1) begin
      errors++; $display("FAIL num_ch_latched: got v=%b d=%h n=%0d want v=1 d=01 n=1", out_valid, out_data, out_nbits);
    end
    num_ch = 8'd0; threshold = 13'd5;
    send(5'd5, 1'b0);
    send(5'd4, 1'b0);
    send(5'd6, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h05 || out_nbits !== 4'd3) begin
      errors++; $display("FAIL num_ch_zero: got v=%b d=%h n=%0d want v=1 d=05 n=3", out_valid, out_data, out_nbits);
    end
    cyc();
  endtask

  task automatic test_pool;
    do_clear();
    operation = 1'b1;
    send(5'h1F, 1'b0);
    send(5'h03, 1'b0);
    send(5'h1E, 1'b0);
    send(5'h01, 1'b0);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pool_no_early_word: got %b want 0", out_valid); end
    flush = 1'b1; cyc(); flush = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL pool_flush_valid: got %b want 1", out_valid); end
    checks++; if (out_data !== 8'h0B) begin errors++; $display("FAIL pool_flush_data: got %h want 0b", out_data); end
    checks++; if (out_nbits !== 4'd4) begin errors++; $display("FAIL pool_flush_nbits: got %0d want 4", out_nbits); end
    cyc();
    flush = 1'b1; cyc(); flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL pool_empty_flush: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] bits;
    bits = 3'b101;
    operation = 1'b1; out_ready = 1'b1;
    mac_valid = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mac_in = {4'b0, bits[i]};
      cyc();
      checks++; if (out_valid !== 1'b1 || out_data !== {7'b0, bits[i]} || out_nbits !== 4'd1) begin
        errors++; $display("FAIL b2b_word%0d: got v=%b d=%h n=%0d want v=1 d=%h n=1", i, out_valid, out_data, out_nbits, {7'b0, bits[i]});
      end
    end
    mac_valid = 1'b0; flush = 1'b0;
    cyc();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure;
    logic [7:0] pat;
    pat = 8'hA5;
    operation = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send({4'b0, pat[i]}, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL bp_word: got v=%b d=%h want v=1 d=a5", out_valid, out_data);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready_low: got %b want 0", in_ready); end
    mac_valid = 1'b1; mac_in = 5'd1;
    cyc(); cyc();
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'hA5) begin
      errors++; $display("FAIL bp_hold: got r=%b v=%b d=%h want r=0 v=1 d=a5", in_ready, out_valid, out_data);
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_release: got %b want 1", in_ready); end
    cyc();
    mac_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b want 0", out_valid); end
    send(5'd1, 1'b0);
    send(5'd1, 1'b0);
    for (int i = 0; i < 5; i++) send(5'd0, 1'b0);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h07 || out_nbits !== 4'd8) begin
      errors++; $display("FAIL bp_next_word: got v=%b d=%h n=%0d want v=1 d=07 n=8", out_valid, out_data, out_nbits);
    end
    cyc();
  endtask

  task automatic test_clear;
    do_clear();
    operation = 1'b0; num_ch = 8'd2; threshold = 13'd13; out_ready = 1'b1;
    send(5'd9, 1'b0);
    mac_valid = 1'b1; mac_in = 5'd9; clear = 1'b1;
    cyc();
    mac_valid = 1'b0; clear = 1'b0;
    send(5'd5, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_pixel_ch1: got %b want 0", out_valid); end
    send(5'd5, 1'b1);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_pixel_ch2: got %b want 0", out_valid); end
    send(5'd5, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_nbits !== 4'd1) begin
      errors++; $display("FAIL clear_pixel_done: got v=%b d=%h n=%0d want v=1 d=01 n=1", out_valid, out_data, out_nbits);
    end
    cyc();
    do_clear();
    operation = 1'b1; out_ready = 1'b0;
    send(5'd1, 1'b0);
    send(5'd1, 1'b1);
    mac_valid = 1'b1; mac_in = 5'd1; clear = 1'b1;
    cyc();
    mac_valid = 1'b0; clear = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h03 || out_nbits !== 4'd2) begin
      errors++; $display("FAIL clear_keeps_word: got v=%b d=%h n=%0d want v=1 d=03 n=2", out_valid, out_data, out_nbits);
    end
    out_ready = 1'b1;
    cyc();
    send(5'd0, 1'b0);
    send(5'd1, 1'b1);
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_nbits !== 4'd2) begin
      errors++; $display("FAIL clear_after_drain: got v=%b d=%h n=%0d want v=1 d=02 n=2", out_valid, out_data, out_nbits);
    end
    cyc();
  endtask

  task automatic test_saturation;
    b_operation = 1'b0; b_num_ch = 8'd9; b_threshold = 5'd31; b_out_ready = 1'b1;
    b_clear = 1'b1; cyc(); b_clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_mac_valid = 1'b1; b_mac_in = 5'd25; b_flush = (i == 9);
      cyc();
    end
    b_mac_valid = 1'b0; b_flush = 1'b0;
    checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h01 || b_out_nbits !== 4'd1) begin
      errors++; $display("FAIL sat_bit: got v=%b d=%h n=%0d want v=1 d=01 n=1", b_out_valid, b_out_data, b_out_nbits);
    end
    cyc();
  endtask

  task automatic test_async_reset;
    logic [7:0] pat;
    pat = 8'h81;
    do_clear();
    operation = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(5'd1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin
      errors++; $display("FAIL areset_pending: got v=%b r=%b d=%h want v=0 r=1 d=00", out_valid, in_ready, out_data);
    end
    @(negedge clk) rst_n = 1'b1;
    cyc();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(5'd1, 1'b0);
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    cyc();
    for (int i = 0; i < 8; i++) begin
      if (i == 7) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_no_early_word: got %b want 0", out_valid); end
      end
      send({4'b0, pat[i]}, 1'b0);
    end
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h81 || out_nbits !== 4'd8) begin
      errors++; $display("FAIL areset_next_word: got v=%b d=%h n=%0d want v=1 d=81 n=8", out_valid, out_data, out_nbits);
    end
    cyc();
  endtask

  initial begin
    test_reset();
    test_conv();
    test_num_ch();
    test_pool();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
